// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and the IF/ID register layout for the fetch stage
package fetch_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;
  localparam int CNT_W   = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus1;
    logic               valid;
  } ifid_t;

endpackage

// File: rtl/fetch_ifid_reg.sv
// rtl/fetch_ifid_reg.sv - IF/ID pipeline register with load and valid-clear controls
module ifid_reg
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear_valid,
  input  ifid_t d,
  output ifid_t q
);

  // A load always wins; clear_valid only squashes a held entry into a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '{instr: NOP_INSTR, pc: '0, pc_plus1: '0, valid: 1'b0};
    end else if (load) begin
      q <= d;
    end else if (clear_valid) begin
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter, next-PC selection, IF/ID capture and fetch counter
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                     ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                     INSTR_W  = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0,
  parameter int                     CNT_W    = fetch_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus1,
  output logic               id_valid,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              load;
  logic              clear_valid;
  logic              count_en;
  ifid_t             ifid_d;
  ifid_t             ifid_q;

  assign pc_inc = pc + 1'b1;

  // Redirect outranks stall; both stop the IF/ID load, and redirect always squashes.
  always_comb begin
    load        = !redirect && !stall;
    clear_valid = redirect || flush;
    count_en    = load && !flush;
    ifid_d      = '{instr: imem_instr, pc: pc, pc_plus1: pc_inc, valid: !flush};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!stall) begin
      pc <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if (count_en && (fetch_count != '1)) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

  ifid_reg u_ifid_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .clear_valid (clear_valid),
    .d           (ifid_d),
    .q           (ifid_q)
  );

  assign imem_addr   = pc;
  assign id_instr    = ifid_q.instr;
  assign id_pc       = ifid_q.pc;
  assign id_pc_plus1 = ifid_q.pc_plus1;
  assign id_valid    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed checks of fetch_stage against a behavioural model
module tb_fetch_stage;

  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          redirect;
  logic [11:0]   redirect_pc;
  logic [11:0]   imem_addr;
  logic [18:0]   imem_instr;
  logic [18:0]   id_instr;
  logic [11:0]   id_pc;
  logic [11:0]   id_pc_plus1;
  logic          id_valid;
  logic [CW-1:0] fetch_count;

  logic [18:0] mem [4096];

  int total;
  int bad;

  logic [11:0] m_pc;
  logic [18:0] m_instr;
  logic [11:0] m_id_pc;
  logic [11:0] m_id_pc1;
  logic        m_valid;
  int          m_cnt;

  fetch_stage #(.RESET_PC(12'd0), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus1 (id_pc_plus1),
    .id_valid    (id_valid),
    .fetch_count (fetch_count)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 12'd0; m_instr = '0; m_id_pc = '0; m_id_pc1 = '0; m_valid = 1'b0; m_cnt = 0;
  endtask

  // One clock edge with the given controls; the model follows the stated priority rules.
  task automatic cycle(input logic r, input logic s, input logic f, input logic [11:0] rpc);
    redirect = r; stall = s; flush = f; redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      m_pc = rpc; m_valid = 1'b0;
    end else if (s) begin
      m_valid = m_valid & ~f;
    end else begin
      m_instr = mem[m_pc]; m_id_pc = m_pc; m_id_pc1 = m_pc + 12'd1; m_valid = ~f;
      if (!f && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_pc = m_pc + 12'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 0; flush = 0; redirect = 0; redirect_pc = '0;
    @(posedge clk); @(posedge clk); #1;
    total++; if (imem_addr !== 12'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", id_valid); end
    total++; if (id_instr !== 19'd0 || id_pc !== 12'd0 || id_pc_plus1 !== 12'd0) begin
      bad++; $display("FAIL reset_ifid: got instr=%0d pc=%0d pc1=%0d want 0", id_instr, id_pc, id_pc_plus1);
    end
    total++; if (fetch_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_free_run();
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 0, 12'd0);
      total++; if (id_pc !== k[11:0] || id_instr !== k[18:0] || id_valid !== 1'b1) begin
        bad++; $display("FAIL free_run: got pc=%0d instr=%0d v=%0b want pc=%0d", id_pc, id_instr, id_valid, k);
      end
      total++; if (fetch_count !== CW'(k + 1)) begin
        bad++; $display("FAIL free_run_count: got %0d want %0d", fetch_count, k + 1);
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 12'd0);
      total++; if (imem_addr !== 12'd8 || id_pc !== 12'd7 || fetch_count !== CW'(8) || id_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold: got addr=%0d pc=%0d cnt=%0d v=%0b want 8 7 8 1",
                        imem_addr, id_pc, fetch_count, id_valid);
      end
    end
    cycle(0, 0, 0, 12'd0);
    total++; if (id_pc !== 12'd8 || id_instr !== 19'd8 || fetch_count !== CW'(9)) begin
      bad++; $display("FAIL stall_resume: got pc=%0d instr=%0d cnt=%0d want 8 8 9", id_pc, id_instr, fetch_count);
    end
    cycle(0, 0, 0, 12'd0);
  endtask

  task automatic test_redirect();
    total++; if (imem_addr !== 12'd10) begin bad++; $display("FAIL redir_pre: got %0d want 10", imem_addr); end
    cycle(1, 0, 0, 12'd100);
    total++; if (imem_addr !== 12'd100 || id_valid !== 1'b0 || id_pc !== 12'd9) begin
      bad++; $display("FAIL redir_bubble: got addr=%0d v=%0b pc=%0d want 100 0 9", imem_addr, id_valid, id_pc);
    end
    cycle(0, 0, 0, 12'd0);
    total++; if (id_pc !== 12'd100 || id_instr !== 19'd100 || id_valid !== 1'b1) begin
      bad++; $display("FAIL redir_target: got pc=%0d instr=%0d v=%0b want 100 100 1", id_pc, id_instr, id_valid);
    end
  endtask

  task automatic test_redirect_stall();
    cycle(1, 1, 1, 12'd50);
    total++; if (imem_addr !== 12'd50 || id_valid !== 1'b0) begin
      bad++; $display("FAIL redir_stall: got addr=%0d v=%0b want 50 0", imem_addr, id_valid);
    end
    cycle(0, 0, 0, 12'd0);
    total++; if (id_pc !== 12'd50 || id_valid !== 1'b1) begin
      bad++; $display("FAIL redir_stall_next: got pc=%0d v=%0b want 50 1", id_pc, id_valid);
    end
  endtask

  task automatic test_wrap();
    cycle(1, 0, 0, 12'd4095);
    cycle(0, 0, 0, 12'd0);
    total++; if (id_pc !== 12'd4095 || id_pc_plus1 !== 12'd0 || imem_addr !== 12'd0) begin
      bad++; $display("FAIL wrap_top: got pc=%0d pc1=%0d addr=%0d want 4095 0 0", id_pc, id_pc_plus1, imem_addr);
    end
    cycle(0, 0, 0, 12'd0);
    total++; if (id_pc !== 12'd0 || id_pc_plus1 !== 12'd1) begin
      bad++; $display("FAIL wrap_zero: got pc=%0d pc1=%0d want 0 1", id_pc, id_pc_plus1);
    end
  endtask

  task automatic test_flush();
    logic [11:0] held;
    held = m_pc;
    cycle(0, 1, 1, 12'd0);
    total++; if (imem_addr !== held || id_valid !== 1'b0) begin
      bad++; $display("FAIL stall_flush: got addr=%0d v=%0b want %0d 0", imem_addr, id_valid, held);
    end
    cycle(0, 0, 0, 12'd0);
    total++; if (id_pc !== held || id_valid !== 1'b1) begin
      bad++; $display("FAIL stall_flush_refetch: got pc=%0d v=%0b want %0d 1", id_pc, id_valid, held);
    end
    cycle(0, 0, 1, 12'd0);
    total++; if (id_valid !== 1'b0 || imem_addr !== held + 12'd2 || fetch_count !== CW'(m_cnt)) begin
      bad++; $display("FAIL flush_only: got v=%0b addr=%0d cnt=%0d want 0 %0d %0d",
                      id_valid, imem_addr, fetch_count, held + 12'd2, m_cnt);
    end
  endtask

  task automatic test_random();
    int errs;
    for (int i = 0; i < 4096; i++) mem[i] = 19'($urandom);
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
            12'($urandom));
      total++;
      errs = 0;
      if (imem_addr !== m_pc) errs++;
      if (id_valid !== m_valid) errs++;
      if (id_instr !== m_instr || id_pc !== m_id_pc || id_pc_plus1 !== m_id_pc1) errs++;
      if (fetch_count !== CW'(m_cnt)) errs++;
      if (errs != 0) begin
        bad++;
        $display("FAIL random[%0d]: got addr=%0d v=%0b instr=%0d pc=%0d pc1=%0d cnt=%0d want %0d %0b %0d %0d %0d %0d",
                 i, imem_addr, id_valid, id_instr, id_pc, id_pc_plus1, fetch_count,
                 m_pc, m_valid, m_instr, m_id_pc, m_id_pc1, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk); rst = 1'b0; #2; rst = 1'b1;
    model_reset();
    for (int k = 0; k < 40; k++) begin
      cycle(0, 0, 0, 12'd0);
      total++; if (fetch_count !== CW'((k + 1 > CMAX) ? CMAX : k + 1)) begin
        bad++; $display("FAIL saturate[%0d]: got %0d want %0d", k, fetch_count, (k + 1 > CMAX) ? CMAX : k + 1);
      end
    end
  endtask

  task automatic test_async_reset();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 12'd77;
    #2; rst = 1'b0; #1;
    total++; if (imem_addr !== 12'd0 || id_valid !== 1'b0 || id_pc !== 12'd0 || id_instr !== 19'd0 ||
                 id_pc_plus1 !== 12'd0 || fetch_count !== '0) begin
      bad++; $display("FAIL async_reset: got addr=%0d v=%0b pc=%0d instr=%0d pc1=%0d cnt=%0d want all 0",
                      imem_addr, id_valid, id_pc, id_instr, id_pc_plus1, fetch_count);
    end
    @(posedge clk); @(negedge clk);
    stall = 1'b0; redirect = 1'b0; rst = 1'b1;
    model_reset();
    cycle(0, 0, 0, 12'd0);
    total++; if (id_pc !== 12'd0 || id_valid !== 1'b1 || id_instr !== mem[0] || imem_addr !== 12'd1 ||
                 fetch_count !== CW'(1)) begin
      bad++; $display("FAIL async_restart: got pc=%0d v=%0b instr=%0d addr=%0d cnt=%0d want 0 1 %0d 1 1",
                      id_pc, id_valid, id_instr, imem_addr, fetch_count, mem[0]);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 19'(i);
    model_reset();
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_flush();
    test_random();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly upstream of the instruction memory. It owns the program counter, drives the 12-bit fetch address into the combinational-read instruction memory, and captures the returned 19-bit instruction into the IF/ID pipeline register. It supports stall, flush and redirect (branch/jump) requests from later stages and keeps a saturating count of valid fetches.

## Interface
Parameters:
- ADDR_W, 12, program-counter / instruction-memory address width
- INSTR_W, 19, instruction width
- RESET_PC, 12'd0, PC value loaded on reset
- CNT_W, 16, width of fetch counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  invalidate IF/ID at next edge
- redirect  in  1  load redirect_pc into PC; implies flush
- redirect_pc  in  ADDR_W  redirect target
- imem_addr  out  ADDR_W  address to instruction memory
- imem_instr  in  INSTR_W  instruction returned same cycle for imem_addr
- id_instr  out  INSTR_W  IF/ID instruction
- id_pc  out  ADDR_W  address id_instr was fetched from
- id_pc_plus1  out  ADDR_W  id_pc + 1 mod 2^ADDR_W
- id_valid  out  1  IF/ID holds a real instruction
- fetch_count  out  CNT_W  number of edges at which IF/ID loaded a valid instruction

## Operation
- imem_addr is the PC register output directly; no combinational path from any input.
- Per rising edge, priority redirect > stall > normal:
  - redirect=1: pc <= redirect_pc; id_valid <= 0; id_instr/id_pc/id_pc_plus1 hold; stall and flush ignored.
  - redirect=0, stall=1: pc holds; id_instr/id_pc/id_pc_plus1 hold; id_valid <= id_valid & ~flush.
  - redirect=0, stall=0: pc <= pc+1; id_instr <= imem_instr; id_pc <= pc; id_pc_plus1 <= pc+1; id_valid <= ~flush.
- PC increment wraps: 4095 + 1 = 0. No overflow flag.
- fetch_count increments by 1 only at edges where normal path loads with flush=0; saturates at 2^CNT_W-1.
- No decode of instruction content; zero instruction is passed through as any other.

## Timing
- Reset (rst=0, asynchronous): pc=RESET_PC, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus1=0, fetch_count=0. Assertion mid-operation overrides any pending stall/redirect immediately.
- Reset release: first edge with rst=1 captures instruction at RESET_PC, id_valid=1, pc=RESET_PC+1.
- Fetch latency: 1 cycle from imem_addr presentation to id_instr.
- Redirect penalty: 1 bubble; target instruction appears in IF/ID 2 edges after redirect sampled.
- Stall held for N cycles: outputs frozen for N edges; fetch resumes at same pc with no loss or duplication.
- Simultaneous stall+flush: PC held, bubble inserted, instruction re-fetched after stall drops.

## Structure
- Package fetch_pkg: ADDR_W, INSTR_W, CNT_W constants; NOP_INSTR = '0; typedef struct packed ifid_t {instr, pc, pc_plus1, valid}.
- One sub-module ifid_reg: IF/ID register holding ifid_t with load/clear-valid controls and async active-low reset; PC, next-PC mux and counter stay in fetch_stage.

## Test plan
- Reset then free-run, memory word k = k: id_pc = 0,1,2,… one per cycle, id_instr = id_pc, id_valid=1 from first edge, fetch_count = cycles since release.
- stall=1 for 3 cycles at pc=8: imem_addr stays 8, id_pc stays 7, fetch_count frozen; after release id_pc=8 next edge.
- redirect=1 with redirect_pc=100 at pc=10: next cycle imem_addr=100, id_valid=0; following edge id_pc=100, id_valid=1.
- redirect and stall together, redirect_pc=50: pc becomes 50, id_valid=0; stall ignored.
- Wrap: redirect to 4095, free-run: id_pc 4095 with id_pc_plus1=0, then id_pc=0.
- rst pulled low mid-stall with redirect pending: outputs immediately at reset values; after release fetch restarts at RESET_PC.
